alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined integer ALU for the Y86-64 execute stage. It generalises the single-function 64-bit combinational XOR into a WIDTH-bit unit implementing all four Y86 OPq functions (ADD, SUB, AND, XOR). The unit has a configurable pipeline depth, valid/ready handshakes on both sides, and a condition-code register updated in program order. It sits between decode (operand source) and memory/write-back (result sink).

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits (≥ 2)
- PIPE, 1, pipeline stages from accept to result (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand bundle present
- in_ready  out  1  unit can accept this cycle
- op  in  2  function: 0=ADD, 1=SUB, 2=AND, 3=XOR (Y86 ifun)
- a  in  WIDTH  valA
- b  in  WIDTH  valB
- set_cc  in  1  update condition codes when this op retires
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result
- result  out  WIDTH  valE
- cc  out  3  {ZF, SF, OF}, registered

## Operation
- Functions, all modulo 2^WIDTH, two's complement:
  - ADD: b + a
  - SUB: b − a (Y86 order)
  - AND: b & a
  - XOR: b ^ a
- Flags are computed per op from that op's result (r):
  - ZF = (r == 0)
  - SF = r[WIDTH-1]
  - OF for ADD: a and b have the same sign, and r's sign differs from it
  - OF for SUB: a and b have different signs, and r's sign differs from b's
  - OF for AND/XOR: 0
- Pipeline: PIPE register slots, each holding a valid bit plus result, flags and set_cc.
  - Compute happens in slot 0. Later slots only forward.
- Global advance: adv = !out_valid || out_ready.
  - When adv=1, every slot shifts one step.
  - Slot 0 loads {in_valid && in_ready, computed bundle}.
- in_ready = adv, combinational. No bubbles are inserted, and no ops are dropped or duplicated.
- out_valid and result come from the last slot.
- CC update:
  - cc loads the last slot's flags only on an output handshake (out_valid && out_ready) where that slot's set_cc=1.
  - Otherwise cc holds.
- Bubbles (valid=0) never modify cc, even while advancing.

## Timing
- Reset values:
  - all slot valid bits 0
  - result 0
  - cc = 3'b100 (ZF=1, SF=0, OF=0)
  - in_ready = 1
- Reset clears all in-flight ops immediately (async). The first accept is possible on the first edge after deassertion.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+PIPE−1 when no stall occurs.
  - PIPE=1: result is visible in the cycle after acceptance.
- Throughput: one op per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0
  - all slots hold
  - result and out_valid stay stable until the handshake
- Simultaneous accept and retire in one cycle is allowed at full throughput.
- cc changes on the edge that completes the retiring handshake, so it is visible the following cycle.
- Mid-pipeline bubbles collapse only through normal shifting; no compaction occurs.

## Configuration
- ALU_CC_EN defined:
  - flag logic and cc register are present
  - behaviour is as above
- ALU_CC_EN undefined:
  - no flag logic and no cc register
  - set_cc is ignored
  - cc output is tied to 3'b000
  - results and handshakes are unchanged

## Test plan
- XOR, WIDTH=64, PIPE=2, a=b=64'hFFFFFFFFFFFFFFFF, set_cc=1 -> result 0 two edges after accept; after retire, cc=3'b100.
- ADD, a=64'h0000000000000001, b=64'h7FFFFFFFFFFFFFFF, set_cc=1 -> result 64'h8000000000000000, cc=3'b011 (SF=1, OF=1).
- SUB, a=1, b=0, set_cc=1 -> result 64'hFFFFFFFFFFFFFFFF, cc=3'b010. Then AND a=64'hF0, b=64'h0F, set_cc=0 -> result 0, cc stays 3'b010.
- Backpressure, PIPE=3: stream XOR ops with b = a+1 for a = ...FE down to ...F6, holding out_ready=0 for 5 cycles once full.
  - While stalled: in_ready=0 and result frozen.
  - After release: the 9 results (1, 3, 1, 7, 1, 3, 1, 15, 1 in low bits) retire in order with no loss or duplication.
- Reset mid-operation: with 2 ops in flight and cc=3'b010, pulse rst for half a cycle -> out_valid=0 and cc=3'b100 immediately; next accepted op retires normally.
- Build without ALU_CC_EN: repeat the ADD overflow case -> result 64'h8000000000000000, cc=3'b000.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand side (in_*) from decode, result side (out_*) to write-back.
// master = the environment driving operands and sinking results; slave = the ALU.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       cc;

  modport master (
    output in_valid, op, a, b, set_cc, out_ready,
    input  in_ready, out_valid, result, cc
  );

  modport slave (
    input  in_valid, op, a, b, set_cc, out_ready,
    output in_ready, out_valid, result, cc
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined Y86-64 OPq ALU (ADD/SUB/AND/XOR) with valid/ready on both sides.
// Define ALU_CC_EN to build the flag logic and the program-order condition-code register.
module alu_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned PIPE  = 1
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  logic             adv;
  logic [WIDTH-1:0] res_d;
  logic [PIPE-1:0]  vld_q;
  logic [WIDTH-1:0] res_q [PIPE];

  // Whole pipe moves as one; a stalled output freezes every slot.
  assign adv           = !vld_q[PIPE-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[PIPE-1];
  assign bus.result    = res_q[PIPE-1];

  // Y86 operand order: b is the destination operand, so SUB is b - a.
  always_comb begin
    res_d = '0;
    unique case (bus.op)
      2'd0:    res_d = bus.b + bus.a;
      2'd1:    res_d = bus.b - bus.a;
      2'd2:    res_d = bus.b & bus.a;
      2'd3:    res_d = bus.b ^ bus.a;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE; i++) res_q[i] <= '0;
    end else if (adv) begin
      vld_q[0] <= bus.in_valid;
      res_q[0] <= res_d;
      for (int i = 1; i < PIPE; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

`ifdef ALU_CC_EN
  logic            sa;
  logic            sb;
  logic            sr;
  logic            of_d;
  logic [2:0]      fl_d;
  logic [2:0]      fl_q [PIPE];
  logic [PIPE-1:0] sc_q;
  logic [2:0]      cc_q;

  assign sa = bus.a[WIDTH-1];
  assign sb = bus.b[WIDTH-1];
  assign sr = res_d[WIDTH-1];

  always_comb begin
    of_d = 1'b0;
    unique case (bus.op)
      2'd0:    of_d = (sa == sb) && (sr != sa);
      2'd1:    of_d = (sa != sb) && (sr != sb);
      default: of_d = 1'b0;
    endcase
  end

  assign fl_d = {res_d == '0, sr, of_d};

  // Flags travel with their op and only commit on the retiring handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q <= '0;
      for (int i = 0; i < PIPE; i++) fl_q[i] <= '0;
      cc_q <= 3'b100;
    end else begin
      if (adv) begin
        fl_q[0] <= fl_d;
        sc_q[0] <= bus.set_cc;
        for (int i = 1; i < PIPE; i++) begin
          fl_q[i] <= fl_q[i-1];
          sc_q[i] <= sc_q[i-1];
        end
      end
      if (vld_q[PIPE-1] && bus.out_ready && sc_q[PIPE-1]) cc_q <= fl_q[PIPE-1];
    end
  end

  assign bus.cc = cc_q;
`else
  logic unused_set_cc;
  assign unused_set_cc = bus.set_cc;
  assign bus.cc        = 3'b000;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases, backpressure, async reset and a random
// stream, all scored against an in-order queue model of the operations in flight.
module tb_alu_pipe;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned PIPE  = 3;

`ifdef ALU_CC_EN
  localparam logic [2:0] CcRst = 3'b100;
  localparam bit         CcEn  = 1'b1;
`else
  localparam logic [2:0] CcRst = 3'b000;
  localparam bit         CcEn  = 1'b0;
`endif

  typedef struct {
    logic [63:0] res;
    logic [2:0]  fl;
    bit          sc;
    int          pos;
  } item_t;

  logic clk = 1'b0;
  logic rst;

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  item_t       q[$];
  logic [2:0]  exp_cc;
  bit          exp_ov;
  bit          last_acc;
  bit          last_ret;
  logic [63:0] last_dut;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on sign-extended operands; overflow when the extra bit disagrees.
  function automatic item_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input bit sc);
    logic [64:0] s;
    logic        of;
    item_t       it;
    of = 1'b0;
    case (op)
      2'd0:    begin s = {b[63], b} + {a[63], a}; of = s[64] ^ s[63]; end
      2'd1:    begin s = {b[63], b} - {a[63], a}; of = s[64] ^ s[63]; end
      2'd2:    s = {1'b0, b & a};
      default: s = {1'b0, b ^ a};
    endcase
    it.res = s[63:0];
    it.fl  = {it.res == 64'd0, it.res[63], of};
    it.sc  = sc;
    it.pos = 0;
    return it;
  endfunction

  task automatic drive(input bit v, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit sc);
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.set_cc   = sc;
  endtask

  // One clock: called at a negedge, returns at the next negedge with outputs checked.
  task automatic tick();
    bit    adv;
    bit    acc;
    bit    ret;
    item_t nit;
    item_t head;
    #1;
    adv = !exp_ov || bus.out_ready;
    check("in_ready", 64'(bus.in_ready), 64'(adv));
    acc = bus.in_valid && adv;
    ret = exp_ov && bus.out_ready;
    if (acc) nit = model(bus.op, bus.a, bus.b, bus.set_cc);
    if (ret) last_dut = bus.result;
    @(posedge clk);
    if (ret) begin
      head = q.pop_front();
      if (CcEn && head.sc) exp_cc = head.fl;
    end
    if (adv) foreach (q[i]) q[i].pos++;
    if (acc) q.push_back(nit);
    last_acc = acc;
    last_ret = ret;
    @(negedge clk);
    exp_ov = (q.size() > 0) && (q[0].pos == int'(PIPE) - 1);
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) check("result", bus.result, q[0].res);
    check("cc", 64'(bus.cc), 64'(exp_cc));
  endtask

  // Single op through an empty pipe with out_ready=1; checks latency, value and retired cc.
  task automatic run_one(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input bit sc, input logic [63:0] want,
                         input logic [2:0] want_cc);
    int k;
    bus.out_ready = 1'b1;
    drive(1'b1, op, a, b, sc);
    tick();
    check({tag, "_acc"}, 64'(last_acc), 64'd1);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    k = 1;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(PIPE));
    check({tag, "_res"}, bus.result, want);
    tick();
    check({tag, "_cc"}, 64'(bus.cc), 64'(CcEn ? want_cc : 3'b000));
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [63:0] got[$];
    logic [63:0] prev;
    logic [7:0]  xor_exp [9];
    logic [63:0] base;
    int          i;
    int          stall;
    bit          pov;

    xor_exp = '{8'd1, 8'd3, 8'd1, 8'd7, 8'd1, 8'd3, 8'd1, 8'd15, 8'd1};
    rst = 1'b1;
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    bus.out_ready = 1'b1;
    exp_cc = CcRst;
    exp_ov = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_cc", 64'(bus.cc), 64'(CcRst));
    rst = 1'b0;

    run_one("xor_ones", 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0,
            3'b100);
    run_one("add_ovf", 2'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000,
            3'b011);

    // Fill the pipe while blocked, hold five stalled cycles, then drain.
    base  = 64'hFFFF_FFFF_FFFF_FFFE;
    i     = 0;
    stall = 0;
    for (int cyc = 0; cyc < 60 && got.size() < 9; cyc++) begin
      if (i < 9) drive(1'b1, 2'd3, base - 64'(i), base - 64'(i) + 64'd1, 1'b1);
      else       drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
      bus.out_ready = (stall >= 5);
      prev = bus.result;
      pov  = bus.out_valid;
      tick();
      if (last_acc) i++;
      if (last_ret) got.push_back(last_dut);
      if (!bus.out_ready && pov) begin
        stall++;
        check("stall_frozen", bus.result, prev);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    check("bp_count", 64'(got.size()), 64'd9);
    foreach (got[j]) if (j < 9) check("bp_order", got[j], 64'(xor_exp[j]));

    run_one("sub_neg", 2'd1, 64'd1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010);
    run_one("and_nocc", 2'd2, 64'hF0, 64'h0F, 1'b0, 64'd0, 3'b010);

    // Two ops in flight with the head stalled at the output, then an async reset pulse.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0, 64'd5, 64'd6, 1'b1);
    tick();
    drive(1'b1, 2'd3, 64'd5, 64'd6, 1'b1);
    tick();
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    tick();
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_cc", 64'(bus.cc), 64'(CcRst));
    check("async_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    exp_cc = CcRst;
    exp_ov = 1'b0;
    @(negedge clk);
    run_one("post_rst", 2'd0, 64'd2, 64'd3, 1'b1, 64'd5, 3'b000);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rnd64(), rnd64(),
            1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 2 * int'(PIPE) + 2; n++) tick();
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
